// File: rtl/sha256_pkg.sv
// Shared SHA-256 front-end definitions: feeder FSM states and the helpers
// that size the padded stream and produce the non-message words.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_OUT,
    ST_DONE
  } feeder_state_t;

  localparam logic [31:0] SHA256_PAD_WORD = 32'h8000_0000;

  // One 0x80000000 word plus a two-word length must fit after the message.
  function automatic logic [15:0] sha256_num_blocks(input logic [15:0] n);
    logic [16:0] s;
    s = {1'b0, n} + 17'd18;
    return {3'b0, s[16:4]};
  endfunction

  function automatic logic [31:0] sha256_pad_word(input logic [15:0] g,
                                                  input logic [15:0] n);
    logic [15:0] nb;
    logic [15:0] last;
    nb   = sha256_num_blocks(n);
    last = (nb << 4) - 16'd1;
    if (g == n)         return SHA256_PAD_WORD;
    else if (g == last) return {11'b0, n, 5'b0};
    else                return 32'h0;
  endfunction

endpackage

// File: rtl/sha256_msg_feeder.sv
// Streams message words from single-port memory followed by in-line SHA-256
// padding, one 32-bit word per valid/ready handshake in block order.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  output logic        busy,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic [31:0] blk_word,
  output logic        blk_word_valid,
  input  logic        blk_word_ready,
  output logic [3:0]  blk_word_idx,
  output logic        blk_first,
  output logic        blk_last
);

  localparam logic [15:0] N      = 16'(NUM_OF_WORDS);
  localparam logic [15:0] NB     = sha256_num_blocks(N);
  localparam logic [15:0] LAST_G = (NB << 4) - 16'd1;

  feeder_state_t r_state, w_next;
  logic [15:0]   r_g, r_base, r_mem_addr;
  logic [31:0]   r_word;
  logic          w_hs, w_at_last;
  logic [15:0]   w_g_inc;

  assign w_hs      = (r_state == ST_OUT) && blk_word_ready;
  assign w_at_last = (r_g == LAST_G);
  assign w_g_inc   = r_g + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_READ;
      ST_READ:    w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_OUT;
      ST_OUT: begin
        if (w_hs) begin
          if (w_at_last)         w_next = ST_DONE;
          else if (w_g_inc < N)  w_next = ST_READ;
        end
      end
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_g        <= '0;
      r_base     <= '0;
      r_mem_addr <= '0;
      r_word     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base <= message_addr;
            r_g    <= '0;
          end
        end
        ST_READ:    r_mem_addr <= r_base + r_g;
        ST_CAPTURE: r_word     <= mem_read_data;
        ST_OUT: begin
          // Pad words need no memory access, so they are produced in place.
          if (w_hs && !w_at_last) begin
            r_g <= w_g_inc;
            if (w_g_inc >= N) r_word <= sha256_pad_word(w_g_inc, N);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign mem_addr       = r_mem_addr;
  assign blk_word       = r_word;
  assign blk_word_valid = (r_state == ST_OUT);
  assign blk_word_idx   = r_g[3:0];
  assign blk_first      = blk_word_valid && (r_g == 16'd0);
  assign blk_last       = blk_word_valid && w_at_last;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Scoreboard bench for sha256_msg_feeder: three instances (N=40, 13, 14)
// share one clock, reset and memory image; one instance is observed at a time.
module tb_sha256_msg_feeder;

  localparam int ND = 3;
  localparam logic [31:0] SEED = 32'h0123_4675;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        start [ND];
  logic [15:0] maddr [ND];
  logic        busy [ND], done [ND], mclk [ND], mwe [ND];
  logic [15:0] mem_addr [ND];
  logic [31:0] rdata [ND], word [ND];
  logic        valid [ND], ready [ND], first [ND], last [ND];
  logic [3:0]  idx [ND];
  logic [31:0] mem [0:255];

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    assign rdata[gi] = mem[mem_addr[gi][7:0]];
    sha256_msg_feeder #(.NUM_OF_WORDS(gi == 0 ? 40 : (gi == 1 ? 13 : 14))) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start[gi]), .message_addr(maddr[gi]),
      .busy(busy[gi]), .done(done[gi]), .mem_clk(mclk[gi]), .mem_we(mwe[gi]),
      .mem_addr(mem_addr[gi]), .mem_read_data(rdata[gi]), .blk_word(word[gi]),
      .blk_word_valid(valid[gi]), .blk_word_ready(ready[gi]),
      .blk_word_idx(idx[gi]), .blk_first(first[gi]), .blk_last(last[gi])
    );
  end

  typedef struct {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        first;
    logic        last;
  } exp_t;

  exp_t sbq[$];
  int tests = 0, fails = 0;
  int hs_cnt = 0, done_cnt = 0, done_cyc = -1, edge_n = 0, sel = 0;
  int hs_cyc [64];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_w = '0;
  logic [3:0]  prev_i = '0;

  // Region 0 holds the rotating seed pattern, region 64 its complement.
  function automatic logic [31:0] exp_word(int n, int g, bit inv);
    int t;
    int r;
    logic [31:0] m;
    t = 16 * ((n + 18) / 16);
    if (g < n) begin
      r = g % 32;
      m = (SEED << r) | (SEED >> ((32 - r) % 32));
      return inv ? ~m : m;
    end
    if (g == n)     return 32'h8000_0000;
    if (g == t - 1) return 32'(n * 32);
    return 32'h0;
  endfunction

  task automatic push_stream(int n, bit inv);
    exp_t e;
    int t;
    t = 16 * ((n + 18) / 16);
    for (int g = 0; g < t; g++) begin
      e.w = exp_word(n, g, inv);
      e.idx = 4'(g);
      e.first = (g == 0);
      e.last = (g == t - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic clear_mon();
    sbq.delete();
    hs_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int k = 0; k < 64; k++) hs_cyc[k] = -1;
  endtask

  task automatic pulse_start(int i, logic [15:0] a, output int s);
    @(posedge clk); #1;
    maddr[i] = a;
    start[i] = 1'b1;
    s = edge_n + 1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done[i] === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_hs(int target, int limit);
    for (int k = 0; k < limit && hs_cnt < target; k++) begin
      @(posedge clk); #1;
    end
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Pops the scoreboard on every handshake of the observed instance and
  // checks that a stalled word holds until it is accepted.
  always @(negedge clk) begin
    exp_t e;
    int c;
    c = edge_n + 1;
    if (reset_n !== 1'b1) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        tests++;
        if (valid[sel] !== 1'b1 || word[sel] !== prev_w || idx[sel] !== prev_i) begin
          fails++;
          $display("FAIL hold: valid=%b word=%h idx=%0d, required valid=1 word=%h idx=%0d",
                   valid[sel], word[sel], idx[sel], prev_w, prev_i);
        end
      end
      if (valid[sel] === 1'b1 && ready[sel] === 1'b1) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL extra_word: got word=%h idx=%0d, required no handshake", word[sel], idx[sel]);
        end else begin
          e = sbq.pop_front();
          if ({word[sel], idx[sel], first[sel], last[sel]} !== {e.w, e.idx, e.first, e.last}) begin
            fails++;
            $display("FAIL stream[%0d]: word=%h idx=%0d first=%b last=%b, required word=%h idx=%0d first=%b last=%b",
                     hs_cnt, word[sel], idx[sel], first[sel], last[sel], e.w, e.idx, e.first, e.last);
          end
        end
        if (hs_cnt < 64) hs_cyc[hs_cnt] = c;
        hs_cnt++;
      end
      if (done[sel] === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      prev_hold = (valid[sel] === 1'b1) && (ready[sel] !== 1'b1);
      prev_w = word[sel];
      prev_i = idx[sel];
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      tests++;
      if ({busy[i], done[i], valid[i], mwe[i]} !== 4'b0) begin
        fails++;
        $display("FAIL reset_ctrl[%0d]: busy=%b done=%b valid=%b we=%b, required all 0",
                 i, busy[i], done[i], valid[i], mwe[i]);
      end
      tests++;
      if ({mem_addr[i], word[i], idx[i], first[i], last[i]} !== 54'b0) begin
        fails++;
        $display("FAIL reset_data[%0d]: addr=%h word=%h idx=%0d first=%b last=%b, required all 0",
                 i, mem_addr[i], word[i], idx[i], first[i], last[i]);
      end
    end
    tests++;
    if (mclk[0] !== clk) begin
      fails++;
      $display("FAIL mem_clk: got %b, required %b", mclk[0], clk);
    end
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy[0] !== 1'b0 || valid[0] !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy[0], valid[0]);
    end
  endtask

  task automatic test_base_stream();
    int s;
    bit ok;
    sel = 0; clear_mon(); push_stream(40, 0); ready[0] = 1'b1;
    pulse_start(0, 16'd0, s);
    tests++;
    if (busy[0] !== 1'b1) begin
      fails++; $display("FAIL busy_in_read: got %b, required 1", busy[0]);
    end
    wait_done(0, 400, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL base_done_timeout: got no done, required done"); end
    tests++;
    if (busy[0] !== 1'b1) begin fails++; $display("FAIL busy_at_done: got %b, required 1", busy[0]); end
    @(negedge clk);
    tests++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      fails++; $display("FAIL after_done: busy=%b done=%b, required 0 0", busy[0], done[0]);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (hs_cnt != 48) begin fails++; $display("FAIL base_count: got %0d, required 48", hs_cnt); end
    tests++;
    if (hs_cyc[0] != s + 3) begin fails++; $display("FAIL first_valid: got %0d, required %0d", hs_cyc[0] - s, 3); end
    tests++;
    if (hs_cyc[39] != s + 120) begin fails++; $display("FAIL last_msg_cycle: got %0d, required 120", hs_cyc[39] - s); end
    tests++;
    if (hs_cyc[47] != s + 128) begin fails++; $display("FAIL last_pad_cycle: got %0d, required 128", hs_cyc[47] - s); end
    tests++;
    if (done_cnt != 1 || done_cyc != s + 129) begin
      fails++; $display("FAIL done_pulse: count=%0d cycle=%0d, required count=1 cycle=129", done_cnt, done_cyc - s);
    end
  endtask

  task automatic test_backpressure();
    int s, n;
    bit ok;
    sel = 0; clear_mon(); push_stream(40, 0); ready[0] = 1'b1;
    pulse_start(0, 16'd0, s);
    wait_hs(2, 100);
    ready[0] = 1'b0;
    n = 0;
    while (valid[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (valid[0] !== 1'b1 || word[0] !== 32'h048D_19D4 || idx[0] !== 4'd2) begin
        fails++;
        $display("FAIL stall[%0d]: valid=%b word=%h idx=%0d, required 1 048d19d4 2", k, valid[0], word[0], idx[0]);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 ready[0] = 1'b1;
    wait_done(0, 400, ok);
    repeat (3) @(negedge clk);
    tests++;
    if (!ok || hs_cnt != 48 || sbq.size() != 0) begin
      fails++; $display("FAIL bp_stream: done=%b count=%0d left=%0d, required 1 48 0", ok, hs_cnt, sbq.size());
    end
  endtask

  task automatic test_single_block();
    int s;
    bit ok;
    sel = 1; clear_mon(); push_stream(13, 1); ready[1] = 1'b1;
    pulse_start(1, 16'd64, s);
    @(posedge clk); #1;
    tests++;
    if (mem_addr[1] !== 16'd64) begin fails++; $display("FAIL base_addr: got %h, required 0040", mem_addr[1]); end
    wait_done(1, 200, ok);
    repeat (3) @(negedge clk);
    tests++;
    if (!ok || hs_cnt != 16 || sbq.size() != 0) begin
      fails++; $display("FAIL n13_stream: done=%b count=%0d left=%0d, required 1 16 0", ok, hs_cnt, sbq.size());
    end
    tests++;
    if (hs_cyc[15] != s + 42 || done_cnt != 1 || done_cyc != s + 43) begin
      fails++; $display("FAIL n13_timing: last=%0d done=%0d cnt=%0d, required 42 43 1", hs_cyc[15] - s, done_cyc - s, done_cnt);
    end
  endtask

  task automatic test_extra_block();
    int s;
    bit ok;
    sel = 2; clear_mon(); push_stream(14, 0); ready[2] = 1'b1;
    pulse_start(2, 16'd0, s);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done[2] === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      ready[2] = ($urandom_range(0, 3) != 0);
    end
    ready[2] = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (!ok || hs_cnt != 32 || sbq.size() != 0 || done_cnt != 1) begin
      fails++; $display("FAIL n14_stream: done=%b count=%0d left=%0d dones=%0d, required 1 32 0 1",
                        ok, hs_cnt, sbq.size(), done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int s;
    bit ok;
    sel = 0; clear_mon(); push_stream(40, 0); ready[0] = 1'b1;
    pulse_start(0, 16'd0, s);
    wait_hs(10, 200);
    maddr[0] = 16'd64;
    start[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, 400, ok);
    repeat (4) @(negedge clk);
    tests++;
    if (!ok || hs_cnt != 48 || sbq.size() != 0 || done_cnt != 1 || busy[0] !== 1'b0) begin
      fails++; $display("FAIL restart_ignored: done=%b count=%0d left=%0d dones=%0d busy=%b, required 1 48 0 1 0",
                        ok, hs_cnt, sbq.size(), done_cnt, busy[0]);
    end
  endtask

  task automatic test_reset_mid();
    int s, n;
    bit ok;
    sel = 0; clear_mon(); push_stream(40, 0); ready[0] = 1'b1;
    pulse_start(0, 16'd0, s);
    wait_hs(20, 300);
    n = 0;
    while (valid[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if ({valid[0], busy[0], done[0]} !== 3'b0) begin
      fails++; $display("FAIL reset_mid: valid=%b busy=%b done=%b, required 0 0 0", valid[0], busy[0], done[0]);
    end
    tests++;
    if ({word[0], idx[0], first[0], last[0]} !== 38'b0) begin
      fails++; $display("FAIL reset_mid_data: word=%h idx=%0d, required 0 0", word[0], idx[0]);
    end
    repeat (2) @(negedge clk);
    sbq.delete();
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt != 0 || busy[0] !== 1'b0) begin
      fails++; $display("FAIL partial_done: dones=%0d busy=%b, required 0 0", done_cnt, busy[0]);
    end
    clear_mon(); push_stream(40, 0);
    pulse_start(0, 16'd0, s);
    wait_done(0, 400, ok);
    repeat (3) @(negedge clk);
    tests++;
    if (!ok || hs_cnt != 48 || sbq.size() != 0 || hs_cyc[0] != s + 3) begin
      fails++; $display("FAIL restart: done=%b count=%0d left=%0d first=%0d, required 1 48 0 3",
                        ok, hs_cnt, sbq.size(), hs_cyc[0] - s);
    end
  endtask

  initial begin
    logic [31:0] r;
    r = SEED;
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    for (int k = 0; k < 64; k++) begin
      mem[k] = r;
      mem[64 + k] = ~r;
      r = {r[30:0], r[31]};
    end
    for (int i = 0; i < ND; i++) begin
      start[i] = 1'b0; maddr[i] = 16'd0; ready[i] = 1'b0;
    end
    clear_mon();
    test_reset();
    test_base_stream();
    test_backpressure();
    test_single_block();
    test_extra_block();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
